// File: rtl/tbtt_beacon_scheduler.sv
// Beacon-start scheduler: aligns the next TBTT to a multiple of the beacon interval on the
// TSF timeline, requests a beacon lead_time_us ahead of it and counts sent/missed beacons.
module tbtt_beacon_scheduler #(
   parameter int TIMER_WIDTH    = 64,
   parameter int INTERVAL_WIDTH = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [INTERVAL_WIDTH-1:0] beacon_interval_tu,
   input  logic [15:0]               lead_time_us,
   input  logic [TIMER_WIDTH-1:0]    tsf_runtime_val,
   input  logic                      tsf_load,
   input  logic                      sent_beacon,
   output logic                      start_beaconing,
   output logic [TIMER_WIDTH-1:0]    next_tbtt,
   output logic [CNT_WIDTH-1:0]      beacon_sent_cnt,
   output logic [CNT_WIDTH-1:0]      beacon_missed_cnt,
   output logic                      calc_busy
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CALC     = 3'd1;
   localparam logic [2:0] S_ALIGN    = 3'd2;
   localparam logic [2:0] S_WAIT     = 3'd3;
   localparam logic [2:0] S_AWAIT_TX = 3'd4;

   localparam int DIV_CNT_W = $clog2(TIMER_WIDTH);
   localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(TIMER_WIDTH - 1);

   logic [2:0]             state;
   logic [TIMER_WIDTH-1:0] snapshot;
   logic [TIMER_WIDTH-1:0] dividend;
   logic [TIMER_WIDTH-1:0] rem;
   logic [TIMER_WIDTH-1:0] interval_us;
   logic [TIMER_WIDTH-1:0] lead;
   logic [DIV_CNT_W-1:0]   div_cnt;

   logic [TIMER_WIDTH-1:0] cfg_interval;
   logic [TIMER_WIDTH-1:0] cfg_lead;
   logic [TIMER_WIDTH-1:0] tp;
   logic [TIMER_WIDTH-1:0] tbtt_step;
   logic [TIMER_WIDTH-1:0] rem_next;
   logic [TIMER_WIDTH:0]   rem_shift;
   logic                   load_cfg;

   assign cfg_interval = {{(TIMER_WIDTH-INTERVAL_WIDTH-10){1'b0}}, beacon_interval_tu, 10'd0};
   assign cfg_lead     = {{(TIMER_WIDTH-16){1'b0}}, lead_time_us};
   assign tp           = tsf_runtime_val + lead;
   assign tbtt_step    = next_tbtt + interval_us;

   // Restoring divider step; the remainder is always below interval_us, so the
   // subtraction can be done modulo 2^TIMER_WIDTH on the low bits.
   assign rem_shift = {rem, dividend[TIMER_WIDTH-1]};
   assign rem_next  = (rem_shift >= {1'b0, interval_us}) ?
                      (rem_shift[TIMER_WIDTH-1:0] - interval_us) : rem_shift[TIMER_WIDTH-1:0];

   // Enable rise in IDLE, or a TSF rewrite in any active state, (re)latches configuration.
   assign load_cfg  = enable && ((state == S_IDLE) ? (cfg_interval != '0) : tsf_load);
   assign calc_busy = (state == S_CALC) || (state == S_ALIGN);

   always_ff @(posedge clk) begin
      if (rst) begin
         snapshot    <= '0;
         dividend    <= '0;
         rem         <= '0;
         interval_us <= '0;
         lead        <= '0;
         div_cnt     <= '0;
      end else if (load_cfg) begin
         snapshot    <= tsf_runtime_val;
         dividend    <= tsf_runtime_val;
         rem         <= '0;
         div_cnt     <= '0;
         interval_us <= cfg_interval;
         lead        <= cfg_lead;
      end else if (state == S_CALC) begin
         dividend <= dividend << 1;
         rem      <= rem_next;
         div_cnt  <= div_cnt + DIV_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         start_beaconing   <= 1'b0;
         next_tbtt         <= '0;
         beacon_sent_cnt   <= '0;
         beacon_missed_cnt <= '0;
      end else begin
         start_beaconing <= 1'b0;
         if (!enable) begin
            state <= S_IDLE;
         end else if (load_cfg) begin
            state <= (cfg_interval == '0) ? S_IDLE : S_CALC;
         end else begin
            case (state)
               S_CALC: begin
                  if (div_cnt == DIV_LAST) begin
                     next_tbtt <= snapshot - rem_next + interval_us;
                     state     <= S_ALIGN;
                  end
               end
               S_ALIGN: begin
                  if (next_tbtt < tp) next_tbtt <= tbtt_step;
                  else                state     <= S_WAIT;
               end
               S_WAIT: begin
                  if (tp >= next_tbtt) begin
                     start_beaconing <= 1'b1;
                     state           <= S_AWAIT_TX;
                  end
               end
               S_AWAIT_TX: begin
                  if (sent_beacon) begin
                     beacon_sent_cnt <= beacon_sent_cnt + CNT_WIDTH'(1);
                     next_tbtt       <= tbtt_step;
                     state           <= S_ALIGN;
                  end else if (tp >= tbtt_step) begin
                     beacon_missed_cnt <= beacon_missed_cnt + CNT_WIDTH'(1);
                     next_tbtt         <= tbtt_step;
                     state             <= S_ALIGN;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tbtt_beacon_scheduler.sv
// Scoreboard bench for tbtt_beacon_scheduler: expected beacon pulses are queued by the
// stimulus side and matched by an independent pulse monitor.
module tb_tbtt_beacon_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] beacon_interval_tu;
   logic [15:0] lead_time_us;
   logic [63:0] tsf_runtime_val;
   logic        tsf_load;
   logic        sent_beacon;
   logic        start_beaconing;
   logic [63:0] next_tbtt;
   logic [15:0] beacon_sent_cnt;
   logic [15:0] beacon_missed_cnt;
   logic        calc_busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [63:0] tbtt;
      logic [15:0] sent;
      logic [15:0] missed;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   logic [63:0] m_tbtt, m_ival, m_lead;
   logic [15:0] m_sent, m_missed;

   tbtt_beacon_scheduler #(
      .TIMER_WIDTH   (64),
      .INTERVAL_WIDTH(16),
      .CNT_WIDTH     (16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .beacon_interval_tu(beacon_interval_tu),
      .lead_time_us      (lead_time_us),
      .tsf_runtime_val   (tsf_runtime_val),
      .tsf_load          (tsf_load),
      .sent_beacon       (sent_beacon),
      .start_beaconing   (start_beaconing),
      .next_tbtt         (next_tbtt),
      .beacon_sent_cnt   (beacon_sent_cnt),
      .beacon_missed_cnt (beacon_missed_cnt),
      .calc_busy         (calc_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Pulse monitor: every start_beaconing cycle must match a queued expectation.
   always @(negedge clk) begin
      if (!rst && start_beaconing) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: got pulse with next_tbtt=%0d, expected no pulse", next_tbtt);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_tbtt", next_tbtt, mon_e.tbtt);
            check("pulse_sent_cnt", 64'(beacon_sent_cnt), 64'(mon_e.sent));
            check("pulse_missed_cnt", 64'(beacon_missed_cnt), 64'(mon_e.missed));
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pulse();
      sb.push_back('{m_tbtt, m_sent, m_missed});
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      check(name, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   // First TBTT: smallest multiple of the interval strictly after the snapshot that is
   // also not before the trigger point (TSF held constant during the calculation).
   function automatic logic [63:0] ref_tbtt(input logic [63:0] snap, input logic [63:0] ival,
                                            input logic [63:0] ld, output int unsigned steps);
      logic [63:0] k1, k2;
      k1 = snap / ival + 64'd1;
      k2 = (snap + ld + ival - 64'd1) / ival;
      if (k2 > k1) begin
         steps = int'(k2 - k1);
         return k2 * ival;
      end
      steps = 0;
      return k1 * ival;
   endfunction

   function automatic logic [63:0] pick_tsf(input logic [63:0] ival, input logic [63:0] ld);
      logic [63:0] t;
      int unsigned s;
      t = {24'd0, 8'($urandom_range(0, 255)), 32'($urandom)};
      while (ref_tbtt(t, ival, ld, s) == t + ld) t = t + 64'd1;
      return t;
   endfunction

   task automatic measure_calc(output int unsigned cnt);
      cnt = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         tsf_load = 1'b0;
         if (calc_busy) cnt++;
         else if (cnt > 0 || i >= 4) break;
      end
   endtask

   task automatic start_cfg(input logic [15:0] tu, input logic [15:0] ld, input logic [63:0] t0);
      int unsigned steps, cnt;
      enable = 1'b0;
      tick();
      tick();
      beacon_interval_tu = tu;
      lead_time_us       = ld;
      tsf_runtime_val    = t0;
      enable             = 1'b1;
      m_ival = 64'(tu) << 10;
      m_lead = 64'(ld);
      m_tbtt = ref_tbtt(t0, m_ival, m_lead, steps);
      measure_calc(cnt);
      check("calc_cycles", 64'(cnt), 64'(65 + steps));
      check("first_tbtt", next_tbtt, m_tbtt);
   endtask

   task automatic reload(input logic [15:0] tu, input logic [15:0] ld, input logic [63:0] t1);
      int unsigned steps, cnt;
      logic [63:0] held;
      held = m_tbtt;
      beacon_interval_tu = tu;
      lead_time_us       = ld;
      tsf_runtime_val    = t1;
      tsf_load           = 1'b1;
      steps = 0;
      if (tu != 16'd0) begin
         m_ival = 64'(tu) << 10;
         m_lead = 64'(ld);
         m_tbtt = ref_tbtt(t1, m_ival, m_lead, steps);
      end
      measure_calc(cnt);
      if (tu != 16'd0) begin
         check("reload_calc_cycles", 64'(cnt), 64'(65 + steps));
         check("reload_tbtt", next_tbtt, m_tbtt);
      end else begin
         check("reload_zero_busy", 64'(cnt), 64'd0);
         check("reload_zero_tbtt_hold", next_tbtt, held);
      end
   endtask

   task automatic fire(input logic [63:0] delta);
      tsf_runtime_val = m_tbtt - m_lead - 64'd1;
      repeat (3) tick();
      push_pulse();
      tsf_runtime_val = m_tbtt - m_lead + delta;
      wait_drain("pulse_seen");
   endtask

   task automatic act_sent();
      sent_beacon = 1'b1;
      tick();
      sent_beacon = 1'b0;
      m_sent = m_sent + 16'd1;
      m_tbtt = m_tbtt + m_ival;
      repeat (3) tick();
      check("sent_tbtt", next_tbtt, m_tbtt);
      check("sent_cnt", 64'(beacon_sent_cnt), 64'(m_sent));
      check("sent_missed_cnt", 64'(beacon_missed_cnt), 64'(m_missed));
   endtask

   task automatic act_miss();
      m_missed = m_missed + 16'd1;
      m_tbtt   = m_tbtt + m_ival;
      push_pulse();
      tsf_runtime_val = m_tbtt - m_lead;
      wait_drain("miss_pulse_seen");
      check("miss_tbtt", next_tbtt, m_tbtt);
      check("miss_cnt", 64'(beacon_missed_cnt), 64'(m_missed));
      check("miss_sent_cnt", 64'(beacon_sent_cnt), 64'(m_sent));
   endtask

   task automatic act_both();
      m_sent = m_sent + 16'd1;
      m_tbtt = m_tbtt + m_ival;
      push_pulse();
      tsf_runtime_val = m_tbtt - m_lead;
      sent_beacon     = 1'b1;
      tick();
      sent_beacon = 1'b0;
      wait_drain("both_pulse_seen");
      check("both_sent_cnt", 64'(beacon_sent_cnt), 64'(m_sent));
      check("both_missed_cnt", 64'(beacon_missed_cnt), 64'(m_missed));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pulse"}, 64'(start_beaconing), 64'd0);
      check({tag, "_tbtt"}, next_tbtt, 64'd0);
      check({tag, "_sent"}, 64'(beacon_sent_cnt), 64'd0);
      check({tag, "_missed"}, 64'(beacon_missed_cnt), 64'd0);
      check({tag, "_busy"}, 64'(calc_busy), 64'd0);
   endtask

   initial begin
      int unsigned cnt;
      logic [15:0] tu, ld;
      rst = 1'b1;
      enable = 1'b0;
      beacon_interval_tu = '0;
      lead_time_us = '0;
      tsf_runtime_val = '0;
      tsf_load = 1'b0;
      sent_beacon = 1'b0;
      m_tbtt = '0; m_ival = '0; m_lead = '0; m_sent = '0; m_missed = '0;
      repeat (3) tick();
      rst = 1'b0;
      check_zero("reset");

      // Zero interval: enable has no effect.
      tsf_runtime_val = 64'd5000;
      enable = 1'b1;
      measure_calc(cnt);
      check("zero_ival_busy", 64'(cnt), 64'd0);
      check_zero("zero_ival");

      // Directed walk-through at 100 TU / 50 us lead.
      start_cfg(16'd100, 16'd50, 64'd1000);
      check("dir_first_tbtt", next_tbtt, 64'd102400);
      fire(64'd0);
      tsf_runtime_val = 64'd102500;
      act_sent();
      check("dir_tbtt_after_sent", next_tbtt, 64'd204800);
      fire(64'd0);
      act_miss();
      act_both();
      act_sent();
      reload(16'd100, 16'd50, 64'd1000000);
      check("dir_reload_tbtt", next_tbtt, 64'd1024000);
      fire(64'd0);

      // Disable while awaiting TX: nothing moves.
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tsf_runtime_val = m_tbtt + 64'($urandom_range(0, 400000));
         sent_beacon = 1'($urandom_range(0, 1));
         tick();
      end
      sent_beacon = 1'b0;
      check("dis_tbtt_hold", next_tbtt, m_tbtt);
      check("dis_sent_hold", 64'(beacon_sent_cnt), 64'(m_sent));
      check("dis_missed_hold", 64'(beacon_missed_cnt), 64'(m_missed));
      check("dis_busy", 64'(calc_busy), 64'd0);

      // Enable after the trigger point of the first multiple.
      start_cfg(16'd100, 16'd50, 64'd102360);
      check("late_enable_tbtt", next_tbtt, 64'd204800);
      fire(64'd7);

      // Reset in the middle of operation.
      rst = 1'b1;
      enable = 1'b0;
      tick();
      rst = 1'b0;
      sb.delete();
      m_tbtt = '0; m_sent = '0; m_missed = '0;
      tick();
      check_zero("mid_reset");

      for (int it = 0; it < 20; it++) begin
         tu = 16'($urandom_range(1, 300));
         ld = 16'($urandom_range(0, 1000));
         start_cfg(tu, ld, pick_tsf(64'(tu) << 10, 64'(ld)));
         for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
            fire(64'($urandom_range(0, 32'(m_ival) - 1)));
            case ($urandom_range(0, 2))
               0: act_sent();
               1: begin act_miss(); act_sent(); end
               default: begin act_both(); act_sent(); end
            endcase
         end
         if ($urandom_range(0, 1) == 1) begin
            tu = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
            ld = 16'($urandom_range(0, 1000));
            reload(tu, ld, (tu == 16'd0) ? 64'd0 : pick_tsf(64'(tu) << 10, 64'(ld)));
            if (tu != 16'd0) begin
               fire(64'd0);
               act_sent();
            end else begin
               repeat (5) tick();
            end
         end
      end

      enable = 1'b0;
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tbtt_beacon_scheduler.md
Name: tbtt_beacon_scheduler

Overview:
Generates the beacon-start request that feeds the TSF tracker's start_beaconing input. It computes the next Target Beacon Transmission Time (TBTT) as a multiple of the beacon interval on the TSF timeline. It fires one pulse lead_time_us before each TBTT, then waits for the sent_beacon handshake. It also counts sent and missed beacons. Sits in xpu between the TSF timer and the beacon TX path.

Parameters:
TIMER_WIDTH, 64, width of TSF values (microseconds)
INTERVAL_WIDTH, 16, width of beacon interval in TU (1 TU = 1024 us)
CNT_WIDTH, 16, width of sent/missed counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  level; 1 = beaconing active
beacon_interval_tu  input  INTERVAL_WIDTH  beacon interval in TU; sampled on enable rise and on tsf_load
lead_time_us  input  16  fire this many us before TBTT; sampled with interval
tsf_runtime_val  input  TIMER_WIDTH  live TSF
tsf_load  input  1  pulse: TSF was rewritten, realign
sent_beacon  input  1  pulse: beacon left the air interface
start_beaconing  output  1  one-cycle pulse, registered
next_tbtt  output  TIMER_WIDTH  TBTT currently scheduled
beacon_sent_cnt  output  CNT_WIDTH  beacons acknowledged via sent_beacon, wraps
beacon_missed_cnt  output  CNT_WIDTH  TBTTs with no sent_beacon, wraps
calc_busy  output  1  1 while in CALC or ALIGN

Behaviour:
- Reset: state IDLE; all outputs 0; internal snapshot, interval_us, lead and divider regs 0.
- interval_us = beacon_interval_tu << 10 (TIMER_WIDTH wide). lead = zero-extended lead_time_us. Trigger point tp = tsf_runtime_val + lead, computed each cycle. All arithmetic is modulo 2^TIMER_WIDTH; wrap is not handled.
- IDLE: if enable=1 and beacon_interval_tu != 0, go to CALC. On that cycle: snapshot tsf_runtime_val, latch interval_us and lead. If interval=0, stay IDLE.
- CALC: restoring divider, 1 quotient bit per cycle, exactly 64 cycles. It computes r = snapshot mod interval_us. On the 64th cycle, next_tbtt <= snapshot - r + interval_us; then go to ALIGN.
- ALIGN: if next_tbtt < tp, then next_tbtt += interval_us (one step per cycle, stay in ALIGN). Else go to WAIT.
- WAIT: when tp >= next_tbtt, start_beaconing=1 for exactly one cycle, then go to AWAIT_TX. sent_beacon in WAIT is ignored.
- AWAIT_TX, priority order:
  - sent_beacon=1: beacon_sent_cnt++, next_tbtt += interval_us, go to ALIGN.
  - else if tp >= next_tbtt + interval_us: beacon_missed_cnt++, next_tbtt += interval_us, go to ALIGN (ALIGN then passes to WAIT, which fires for the new TBTT).
- Simultaneous sent_beacon and timeout in the same cycle: the sent case wins.
- tsf_load=1 in any non-IDLE state (priority over everything except enable=0 and rst): re-snapshot TSF, re-latch interval and lead, restart CALC from cycle 0. No pulse is emitted in that cycle. If the re-latched interval is 0, go to IDLE instead.
- enable=0 in any state: go to IDLE next cycle, and start_beaconing=0 that cycle. next_tbtt and counters hold their values.
- Config changes while enabled are ignored until the next enable rise or tsf_load.
- start_beaconing is never asserted in IDLE, CALC or ALIGN. It is asserted at most once per TBTT.
- rst mid-operation: immediate return to reset values on the next edge.

Test Plan:
- interval=100 TU (102400 us), lead=50, TSF=1000 at enable rise -> calc_busy high ≥65 cycles; next_tbtt=102400; start_beaconing single pulse in the cycle after tsf_runtime_val reaches 102350.
- Continue: sent_beacon at TSF 102500 -> beacon_sent_cnt=1, next_tbtt=204800; next pulse once TSF ≥204750.
- No sent_beacon after first pulse -> at TSF 204750: beacon_missed_cnt=1, next_tbtt=204800, a pulse follows within 3 cycles; sent_cnt stays 0.
- TSF jumps to 1000000 with tsf_load pulse while in WAIT -> no pulse; after CALC, next_tbtt=1024000 (r=78400); pulse at TSF 1023950.
- enable low during AWAIT_TX -> IDLE, no pulses while low; sent_beacon ignored; counters hold. Interval=0 on enable -> stays IDLE, outputs 0.
- Enable at TSF=102360 (past tp of 102400) -> ALIGN advances to next_tbtt=204800, no immediate pulse; sent_beacon and timeout in the same cycle -> sent_cnt increments, missed_cnt unchanged.
